// File: rtl/synapse_unit.sv
// Synapse lookup stage: accepts dispatcher indices, reads weight/target, queues weighted fires.
// Optional UCASPIAN_SYN_COUNT_EN adds a saturating handshaked-fire counter (fire_count).
module synapse_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned TARGET_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         syn_vld,
  input  logic [ADDR_W-1:0]            syn_addr,
  output logic                         syn_rdy,
  input  logic                         cfg_wr,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [WEIGHT_W+TARGET_W-1:0] cfg_data,
  output logic                         fire_vld,
  output logic [WEIGHT_W-1:0]          fire_weight,
  output logic [TARGET_W-1:0]          fire_target,
  input  logic                         fire_rdy,
`ifdef UCASPIAN_SYN_COUNT_EN
  output logic [15:0]                  fire_count,
`endif
  output logic                         idle
);

  localparam int unsigned DATA_W = WEIGHT_W + TARGET_W;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned FIFO_D = 3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] fifo_mem [FIFO_D];
  logic [DATA_W-1:0] head;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        fifo_count;
  logic              inflight;
  logic              run_q;
  logic              accept;
  logic              push;
  logic              pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check counts the pending read so a push always finds a free slot.
  assign syn_rdy = run_q && enable && !cfg_wr &&
                   ((3'({1'b0, fifo_count}) + 3'({2'b0, inflight})) < 3'd3);
  assign accept      = syn_vld && syn_rdy;
  assign push        = inflight;
  assign pop         = fire_vld && fire_rdy;
  assign head        = fifo_mem[rd_ptr];
  assign fire_vld    = (fifo_count != 2'd0);
  assign fire_weight = head[DATA_W-1:TARGET_W];
  assign fire_target = head[TARGET_W-1:0];
  assign idle        = !inflight && (fifo_count == 2'd0);

  // Synapse memory: contents survive reset; reads never coincide with writes.
  always_ff @(posedge clk) begin
    if (cfg_wr) mem[cfg_addr] <= cfg_data;
    if (accept) rd_data <= mem[syn_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      inflight   <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 2'd0;
      for (int i = 0; i < FIFO_D; i++) fifo_mem[i] <= '0;
    end else begin
      run_q    <= 1'b1;
      inflight <= accept;
      if (push) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + 2'd1;
      else if (!push && pop) fifo_count <= fifo_count - 2'd1;
    end
  end

`ifdef UCASPIAN_SYN_COUNT_EN
  // Saturating count of delivered fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         fire_count <= 16'd0;
    else if (pop && fire_count != 16'hFFFF) fire_count <= fire_count + 16'd1;
  end
`endif

endmodule
